// File: rtl/gpio_stim_pkg.sv
// Shared types for the GPIO stimulus sequencer: step opcodes, step-table entry and FSM states.
package gpio_stim_pkg;

    localparam int unsigned STEP_NUM_CH = 32;
    localparam int unsigned STEP_CNT_W  = 24;
    localparam int unsigned STEP_SEL_W  = $clog2(STEP_NUM_CH);

    typedef enum logic [1:0] {
        DRIVE   = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2,
        END     = 2'd3
    } step_op_e;

    typedef struct packed {
        step_op_e                op;
        logic [STEP_SEL_W-1:0]   sel;
        logic [STEP_NUM_CH-1:0]  mask;
        logic [STEP_NUM_CH-1:0]  value;
        logic [STEP_CNT_W-1:0]   count;
    } step_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HOLD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/gpio_stim_table.sv
// Step-table register file: synchronous write, asynchronous read, every entry resets to END.
module gpio_stim_table
    import gpio_stim_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  step_t                    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output step_t                    rdata
);

    step_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '{op: END, default: '0};
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/gpio_stim_sequencer.sv
// GPIO stimulus sequencer: replays DRIVE / WAIT / END steps onto stim_o with a supervised wait timeout.
module gpio_stim_sequencer
    import gpio_stim_pkg::*;
#(
    parameter int unsigned       NUM_CH   = STEP_NUM_CH,
    parameter int unsigned       DEPTH    = 16,
    parameter int unsigned       CNT_W    = STEP_CNT_W,
    parameter int unsigned       TMO_W    = 32,
    parameter logic [NUM_CH-1:0] STIM_RST = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we_i,
    input  logic [$clog2(DEPTH)-1:0]  cfg_addr_i,
    input  logic [1:0]                cfg_op_i,
    input  logic [$clog2(NUM_CH)-1:0] cfg_sel_i,
    input  logic [NUM_CH-1:0]         cfg_mask_i,
    input  logic [NUM_CH-1:0]         cfg_value_i,
    input  logic [CNT_W-1:0]          cfg_count_i,
    input  logic [TMO_W-1:0]          tmo_limit_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [NUM_CH-1:0]         mon_i,
    output logic [NUM_CH-1:0]         stim_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic [$clog2(DEPTH)-1:0]  pc_o
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned SEL_W  = $clog2(NUM_CH);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [NUM_CH-1:0] stim_d;
    logic              busy_d, done_d, timeout_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    step_t             wr_entry, entry;
    logic              table_we;
    logic              last_c, match_c, tmo_hit_c;
    logic [NUM_CH-1:0] mask_c, value_c;

    // The table only accepts writes while no run is in progress.
    assign table_we = cfg_we_i && (state_q == ST_IDLE || state_q == ST_DONE);

    assign wr_entry = '{
        op:    step_op_e'(cfg_op_i),
        sel:   STEP_SEL_W'(cfg_sel_i),
        mask:  STEP_NUM_CH'(cfg_mask_i),
        value: STEP_NUM_CH'(cfg_value_i),
        count: STEP_CNT_W'(cfg_count_i)
    };

    gpio_stim_table #(.DEPTH(DEPTH)) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (table_we),
        .waddr (cfg_addr_i),
        .wdata (wr_entry),
        .raddr (pc_o),
        .rdata (entry)
    );

    assign mask_c    = NUM_CH'(entry.mask);
    assign value_c   = NUM_CH'(entry.value);
    assign last_c    = (pc_o == ADDR_W'(DEPTH - 1));
    assign match_c   = (mon_i[SEL_W'(entry.sel)] == (entry.op == WAIT_HI));
    assign tmo_hit_c = (tmo_limit_i != '0) && (tmo_q == tmo_limit_i - TMO_W'(1));

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_o      <= '0;
            stim_o    <= STIM_RST;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
            hold_q    <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_o      <= pc_d;
            stim_o    <= stim_d;
            busy_o    <= busy_d;
            done_o    <= done_d;
            timeout_o <= timeout_d;
            hold_q    <= hold_d;
            tmo_q     <= tmo_d;
        end
    end

    // Next-state logic; abort overrides everything, including a simultaneous start.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: if (start_i) state_d = ST_FETCH;
                ST_FETCH: begin
                    unique case (entry.op)
                        DRIVE: begin
                            if (entry.count != '0) state_d = ST_HOLD;
                            else                   state_d = last_c ? ST_DONE : ST_FETCH;
                        end
                        WAIT_HI, WAIT_LO: state_d = ST_WAIT;
                        END:              state_d = ST_DONE;
                        default:          state_d = ST_DONE;
                    endcase
                end
                ST_HOLD: if (hold_q == '0) state_d = last_c ? ST_DONE : ST_FETCH;
                ST_WAIT: begin
                    if (match_c)        state_d = last_c ? ST_DONE : ST_FETCH;
                    else if (tmo_hit_c) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        pc_d      = pc_o;
        stim_d    = stim_o;
        hold_d    = hold_q;
        tmo_d     = tmo_q;
        done_d    = done_o;
        timeout_d = timeout_o;
        busy_d    = (state_d == ST_FETCH) || (state_d == ST_HOLD) || (state_d == ST_WAIT);

        if (!abort_i) begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        pc_d      = '0;
                        done_d    = 1'b0;
                        timeout_d = 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (entry.op == DRIVE) begin
                        stim_d = (stim_o & ~mask_c) | (value_c & mask_c);
                        hold_d = CNT_W'(entry.count) - CNT_W'(1);
                    end
                    tmo_d = '0;
                end
                ST_HOLD: if (hold_q != '0) hold_d = hold_q - CNT_W'(1);
                ST_WAIT: if (!match_c && tmo_q != '1) tmo_d = tmo_q + TMO_W'(1);
                default: ;
            endcase

            if (state_q != ST_IDLE && state_q != ST_DONE) begin
                if (state_d == ST_FETCH) pc_d = pc_o + ADDR_W'(1);
                if (state_d == ST_DONE)  done_d = 1'b1;
                if (state_q == ST_WAIT && state_d == ST_DONE && !match_c) timeout_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpio_stim_sequencer.sv
// Directed bench for gpio_stim_sequencer; expected values queue up as stimulus is driven.
module tb_gpio_stim_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [1:0]  cfg_op;
    logic [4:0]  cfg_sel;
    logic [31:0] cfg_mask, cfg_value;
    logic [23:0] cfg_count;
    logic [31:0] tmo_limit;
    logic        start, abort;
    logic [31:0] mon;
    logic [31:0] stim;
    logic        busy, done, timeout;
    logic [3:0]  pc;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    gpio_stim_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_op_i    (cfg_op),
        .cfg_sel_i   (cfg_sel),
        .cfg_mask_i  (cfg_mask),
        .cfg_value_i (cfg_value),
        .cfg_count_i (cfg_count),
        .tmo_limit_i (tmo_limit),
        .start_i     (start),
        .abort_i     (abort),
        .mon_i       (mon),
        .stim_o      (stim),
        .busy_o      (busy),
        .done_o      (done),
        .timeout_o   (timeout),
        .pc_o        (pc)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_val(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prog(input int addr, input logic [1:0] op, input int sel,
                        input logic [31:0] mask, input logic [31:0] value, input logic [23:0] count);
        cfg_addr  = 4'(addr);
        cfg_op    = op;
        cfg_sel   = 5'(sel);
        cfg_mask  = mask;
        cfg_value = value;
        cfg_count = count;
        cfg_we    = 1'b1;
        tick(1);
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_op = '0; cfg_sel = '0;
        cfg_mask = '0; cfg_value = '0; cfg_count = '0; tmo_limit = '0;
        start = 1'b0; abort = 1'b0; mon = '0;
        tick(2);
        rst = 1'b0;

        // Reset state
        expect_val(64'd0); expect_val(64'd0); expect_val(64'd0); expect_val(64'd0); expect_val(64'd0);
        check("rst_stim", 64'(stim));
        check("rst_busy", 64'(busy));
        check("rst_done", 64'(done));
        check("rst_tmo",  64'(timeout));
        check("rst_pc",   64'(pc));

        // Pulse of width count+1 on stim[4]
        prog(0, 2'd0, 0, 32'h10, 32'h10, 24'd3);
        prog(1, 2'd0, 0, 32'h10, 32'h00, 24'd0);
        prog(2, 2'd3, 0, 32'h00, 32'h00, 24'd0);
        pulse_start();
        expect_val(64'd1); expect_val(64'd0);
        check("p_busy", 64'(busy));
        check("p_pre",  64'(stim[4]));
        tick(1);
        expect_val(64'd1); check("p_rise", 64'(stim[4]));
        tick(3);
        expect_val(64'd1); check("p_hold", 64'(stim[4]));
        tick(1);
        expect_val(64'd0); expect_val(64'd0);
        check("p_fall", 64'(stim[4]));
        check("p_notdone", 64'(done));
        tick(1);
        expect_val(64'd1); expect_val(64'd0); expect_val(64'd2);
        check("p_done", 64'(done));
        check("p_idle", 64'(busy));
        check("p_pc",   64'(pc));

        // WAIT_HI released by mon[0] 100 cycles after start
        prog(0, 2'd1, 0, 32'h00, 32'h00, 24'd0);
        prog(1, 2'd0, 0, 32'h08, 32'h08, 24'd0);
        prog(2, 2'd3, 0, 32'h00, 32'h00, 24'd0);
        pulse_start();
        tick(99);
        expect_val(64'd1); expect_val(64'd0);
        check("w_busy", 64'(busy));
        check("w_notdone", 64'(done));
        mon[0] = 1'b1;
        tick(1);
        expect_val(64'd0); check("w_stim_early", 64'(stim[3]));
        tick(1);
        expect_val(64'd1); check("w_stim", 64'(stim[3]));
        tick(1);
        expect_val(64'd1); expect_val(64'd0); expect_val(64'h08);
        check("w_done", 64'(done));
        check("w_tmo",  64'(timeout));
        check("w_stim_all", 64'(stim));
        mon[0] = 1'b0;

        // Same table, timeout after 50 WAIT cycles
        tmo_limit = 32'd50;
        pulse_start();
        expect_val(64'd0); check("t_clr", 64'(done));
        tick(50);
        expect_val(64'd0); check("t_early", 64'(done));
        tick(1);
        expect_val(64'd1); expect_val(64'd1); expect_val(64'h08); expect_val(64'd0); expect_val(64'd0);
        check("t_done", 64'(done));
        check("t_tmo",  64'(timeout));
        check("t_stim", 64'(stim));
        check("t_pc",   64'(pc));
        check("t_busy", 64'(busy));

        // Full table of zero-count DRIVEs, ends without wrapping
        for (int i = 0; i < 16; i++) prog(i, 2'd0, 0, 32'hFFFF_FFFF, 32'(i), 24'd0);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            tick(1);
            expect_val(64'(i));
            expect_val(64'(i < 15 ? i + 1 : 15));
            check("s_stim", 64'(stim));
            check("s_pc",   64'(pc));
        end
        expect_val(64'd1); expect_val(64'd0); expect_val(64'd0);
        check("s_done", 64'(done));
        check("s_busy", 64'(busy));
        check("s_tmo",  64'(timeout));
        tick(2);
        expect_val(64'd15); check("s_pc_hold", 64'(pc));

        // Abort+start mid-HOLD; writes during the run are dropped
        prog(0, 2'd0, 0, 32'hFF, 32'hA5, 24'd1000);
        prog(1, 2'd0, 0, 32'hFF, 32'h3C, 24'd0);
        prog(2, 2'd3, 0, 32'h00, 32'h00, 24'd0);
        pulse_start();
        tick(1);
        expect_val(64'hA5); check("a_stim", 64'(stim));
        tick(10);
        prog(0, 2'd0, 0, 32'hFF, 32'h11, 24'd0);
        expect_val(64'd1); check("a_busy", 64'(busy));
        abort = 1'b1; start = 1'b1;
        tick(1);
        abort = 1'b0; start = 1'b0;
        expect_val(64'd0); expect_val(64'hA5); expect_val(64'd0);
        check("a_idle", 64'(busy));
        check("a_keep", 64'(stim));
        check("a_done", 64'(done));
        tick(3);
        expect_val(64'd0); check("a_stay", 64'(busy));
        pulse_start();
        tick(1);
        expect_val(64'hA5); check("r_stim0", 64'(stim));
        tick(1000);
        expect_val(64'hA5); expect_val(64'd1);
        check("r_hold_end", 64'(stim));
        check("r_busy", 64'(busy));
        tick(1);
        expect_val(64'h3C); check("r_stim1", 64'(stim));
        tick(1);
        expect_val(64'd1); check("r_done", 64'(done));

        // Reset mid-run clears outputs and the table
        pulse_start();
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_val(64'd0); expect_val(64'd0); expect_val(64'd0); expect_val(64'd0); expect_val(64'd0);
        check("x_stim", 64'(stim));
        check("x_busy", 64'(busy));
        check("x_done", 64'(done));
        check("x_tmo",  64'(timeout));
        check("x_pc",   64'(pc));
        pulse_start();
        tick(1);
        expect_val(64'd1); expect_val(64'd0); expect_val(64'd0); expect_val(64'd0);
        check("x_end_done", 64'(done));
        check("x_end_busy", 64'(busy));
        check("x_end_pc",   64'(pc));
        check("x_end_stim", 64'(stim));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_stim_sequencer.md
Name: gpio_stim_sequencer

Overview:
- Synthesizable, parametrised GPIO stimulus sequencer.
- Replays a programmed table of drive, wait-on-input and end steps onto a GPIO input vector.
- Supervises the run with a wait timeout and exposes done/timeout status.
- Sits between the platform GPIO pads and a controller (bench host or debug bridge); replaces per-test hand-written pulse sequences with one programmable engine.

Parameters:
- NUM_CH, 32, number of stimulus/monitor channels.
- DEPTH, 16, step-table entries (power of two, >=2).
- CNT_W, 24, hold-count width per step.
- TMO_W, 32, wait-timeout counter width.
- STIM_RST, '0, stim_o value after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cfg_we_i  in  1  table write strobe.
- cfg_addr_i  in  $clog2(DEPTH)  table write index.
- cfg_op_i  in  2  step opcode: 0 DRIVE, 1 WAIT_HI, 2 WAIT_LO, 3 END.
- cfg_sel_i  in  $clog2(NUM_CH)  monitored bit for WAIT ops.
- cfg_mask_i  in  NUM_CH  DRIVE bit mask.
- cfg_value_i  in  NUM_CH  DRIVE values.
- cfg_count_i  in  CNT_W  DRIVE hold cycles.
- tmo_limit_i  in  TMO_W  WAIT timeout in cycles; 0 disables the timeout.
- start_i  in  1  start a run at entry 0.
- abort_i  in  1  stop the run.
- mon_i  in  NUM_CH  monitored signals (e.g. gpio_out).
- stim_o  out  NUM_CH  stimulus (e.g. gpio_in).
- busy_o  out  1  run in progress.
- done_o  out  1  sticky; the run ended.
- timeout_o  out  1  sticky; the run ended by timeout.
- pc_o  out  $clog2(DEPTH)  current step index.

Behaviour:
- Reset (rst=1 at an edge):
  - stim_o=STIM_RST; busy_o=0; done_o=0; timeout_o=0; pc_o=0.
  - All table entries become op=END with mask, value and count 0.
  - The FSM enters IDLE.
  - mon_i is not synchronised; it is sampled directly.
- FSM states: IDLE, FETCH, HOLD, WAIT, DONE. busy_o=1 in FETCH, HOLD and WAIT.
- IDLE or DONE: start_i at edge N:
  - pc=0, done_o=0, timeout_o=0, busy_o=1 after edge N.
  - FSM enters FETCH.
- FETCH: evaluates entry[pc] in one cycle.
  - DRIVE: stim_o <= (stim_o & ~mask) | (value & mask). If count==0, next state is FETCH with pc+1; otherwise load the hold counter and enter HOLD.
  - WAIT_HI / WAIT_LO: clear the timeout counter and enter WAIT.
  - END: enter DONE, done_o=1, busy_o=0.
- HOLD: decrement per cycle. The exit edge loads pc+1 and enters FETCH.
  - Consecutive DRIVE updates are separated by exactly count+1 cycles.
  - The first stim_o change follows edge N+1.
- WAIT:
  - Exits to FETCH with pc+1 on the first edge where mon_i[sel] matches (1 for WAIT_HI, 0 for WAIT_LO).
  - Otherwise the timeout counter increments. When tmo_limit_i!=0 and the counter reaches tmo_limit_i-1 without a match, enter DONE with done_o=1 and timeout_o=1.
  - A match and a timeout on the same edge: the match wins.
- Table end: advancing from pc=DEPTH-1 with an op other than END enters DONE directly; pc does not wrap.
- Table writes (cfg_we_i):
  - Take effect at the next edge, only in IDLE or DONE.
  - Writes while busy_o=1 are ignored.
- start_i while busy_o=1 is ignored.
- abort_i:
  - From any state, enters IDLE at the next edge with busy_o=0.
  - done_o, timeout_o and stim_o hold their values.
  - abort_i and start_i together: abort wins.
- rst mid-run: full reset as above.
- Counter widths saturate at their parameter widths. There is no arithmetic overflow, because the counters are compared against loaded values.

Decomposition:
- Package gpio_stim_pkg holds:
  - the opcode enum step_op_e (DRIVE, WAIT_HI, WAIT_LO, END);
  - the packed step_t struct {op, sel, mask, value, count};
  - the FSM state enum.
- Sub-module gpio_stim_table: the DEPTH x step_t register file. It has a synchronous write, an asynchronous read and reset to END.
- The sequencer FSM, hold counter and timeout counter live in gpio_stim_sequencer.

Test Plan:
- Program entry0 DRIVE mask=0x10 value=0x10 count=3, entry1 DRIVE mask=0x10 value=0 count=0, entry2 END; pulse start -> stim_o[4] rises one cycle after start, falls exactly 4 cycles later, then done_o=1 and busy_o=0.
- Program entry0 WAIT_HI sel=0, entry1 DRIVE mask=0x08 value=0x08, entry2 END; raise mon_i[0] 100 cycles after start -> stim_o[3]=1 two cycles after the mon_i edge, done_o=1, timeout_o=0.
- Same table, tmo_limit_i=50, mon_i held 0 -> done_o=1 and timeout_o=1 at cycle 50 of WAIT; stim_o unchanged; pc_o=0.
- Program all 16 entries as DRIVE count=0 with value=entry index -> stim_o steps 0..15 on consecutive cycles, then DONE without wrap; pc_o=15.
- Mid-HOLD (count=1000): assert abort_i and start_i together -> IDLE, busy_o=0, stim_o retained. A cfg write during the run is ignored; a subsequent start replays the original table.
- Mid-run rst=1 -> stim_o=STIM_RST, all flags 0, table reset to END; a following start gives an immediate done_o=1.
